// File: rtl/seg_scan_decoder.sv
// Seven-segment scan readback: registers the multiplexed display bus, waits for each
// position's pattern to hold steady, decodes it, and presents whole frames on valid/ready.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            segments,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   frame_digits,
  output logic [DIGITS-1:0]     frame_blank,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Returns {blank, err, value}.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'h7E:   r = {2'b00, 4'd0};
      7'h30:   r = {2'b00, 4'd1};
      7'h6D:   r = {2'b00, 4'd2};
      7'h79:   r = {2'b00, 4'd3};
      7'h33:   r = {2'b00, 4'd4};
      7'h5B:   r = {2'b00, 4'd5};
      7'h5F:   r = {2'b00, 4'd6};
      7'h70:   r = {2'b00, 4'd7};
      7'h7F:   r = {2'b00, 4'd8};
      7'h7B:   r = {2'b00, 4'd9};
      7'h00:   r = {2'b10, 4'hF};
      default: r = {2'b01, 4'hE};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [6:0]          seg_p0_q, seg_p1_q;
  logic [DIGITS-1:0]   sel_p0_q, sel_p1_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [3:0]          val_q [DIGITS];
  logic [3:0]          val_d [DIGITS];
  logic [DIGITS-1:0]   blank_q, blank_d, err_q, err_d;
  logic                fv_q, fv_d, ovr_q, ovr_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   oblank_q, oblank_d, oerr_q, oerr_d;

  logic       changed, onehot, capture, complete, out_free;
  logic [5:0] dec;

  // Stage 1: stability tracking on the registered bus copy
  always_comb begin
    changed = {seg_p0_q, sel_p0_q} != {seg_p1_q, sel_p1_q};
    onehot  = (sel_p0_q != '0) && ((sel_p0_q & (sel_p0_q - DIGITS'(1))) == '0);
    if (!onehot)      cnt_d = '0;
    else if (changed) cnt_d = CNT_W'(1);
    else              cnt_d = sat_inc(cnt_q);
    // Fires only on the transition into CNT_MAX, so a held pair captures once.
    capture = onehot && (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX));
  end

  // Stage 2: capture into shadow slots and frame hand-off
  always_comb begin
    dec      = decode_seg(seg_p0_q);
    seen_d   = seen_q;
    val_d    = val_q;
    blank_d  = blank_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ovr_d    = ovr_q;
    digits_d = digits_q;
    oblank_d = oblank_q;
    oerr_d   = oerr_q;
    out_free = !fv_q || frame_ready;
    if (capture) begin
      seen_d = seen_q | sel_p0_q;
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_p0_q[i]) begin
          val_d[i]   = dec[3:0];
          blank_d[i] = dec[5];
          err_d[i]   = dec[4];
        end
      end
    end
    complete = capture && (&seen_d);
    if (complete) begin
      seen_d = '0;
      if (out_free) begin
        fv_d     = 1'b1;
        oblank_d = blank_d;
        oerr_d   = err_d;
        for (int i = 0; i < DIGITS; i++) digits_d[4*i +: 4] = val_d[i];
      end else begin
        ovr_d = 1'b1;
      end
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p0_q <= '0;
      sel_p0_q <= '0;
      seg_p1_q <= '0;
      sel_p1_q <= '0;
      cnt_q    <= '0;
      seen_q   <= '0;
      for (int i = 0; i < DIGITS; i++) val_q[i] <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      digits_q <= '0;
      oblank_q <= '0;
      oerr_q   <= '0;
    end else begin
      seg_p0_q <= segments;
      sel_p0_q <= digit_sel;
      seg_p1_q <= seg_p0_q;
      sel_p1_q <= sel_p0_q;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      val_q    <= val_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ovr_q    <= ovr_d;
      digits_q <= digits_d;
      oblank_q <= oblank_d;
      oerr_q   <= oerr_d;
    end
  end

  assign frame_valid  = fv_q;
  assign overrun      = ovr_q;
  assign frame_digits = digits_q;
  assign frame_blank  = oblank_q;
  assign frame_err    = oerr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus randomized scanning, checked
// against a window-based reference model of the display readback rules.
module tb_seg_scan_decoder;
  localparam int DIGITS = 4;
  localparam int S      = 4;
  localparam int PW     = 7 + DIGITS;
  localparam int OW     = 2 + 6 * DIGITS;
  localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                      7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [6:0]            segments = '0;
  logic [DIGITS-1:0]     digit_sel = '0;
  logic                  frame_ready = 1'b0;
  logic                  frame_valid;
  logic [4*DIGITS-1:0]   frame_digits;
  logic [DIGITS-1:0]     frame_blank, frame_err;
  logic                  overrun;

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .segments(segments), .digit_sel(digit_sel),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_digits(frame_digits),
    .frame_blank(frame_blank), .frame_err(frame_err), .overrun(overrun));

  always #5 clk = ~clk;

  int cmp = 0;
  int fails = 0;

  // Reference model: hist[j] is the stage-register content j edges ago.
  logic [PW-1:0]       hist [0:S];
  logic [3:0]          m_val [DIGITS];
  logic [DIGITS-1:0]   m_bl, m_er, m_seen, m_obl, m_oer;
  logic [4*DIGITS-1:0] m_dig;
  logic                m_fv, m_ovr;

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int v = 0; v < 10; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      if (p == PAT[v]) return {2'b00, vv};
    end
    if (p == 7'h00) return {2'b10, 4'hF};
    return {2'b01, 4'hE};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {frame_valid, overrun, frame_blank, frame_err, frame_digits};
  endfunction

  function automatic logic [OW-1:0] expm();
    return {m_fv, m_ovr, m_obl, m_oer, m_dig};
  endfunction

  task automatic model_clear();
    for (int j = 0; j <= S; j++) hist[j] = '0;
    for (int k = 0; k < DIGITS; k++) m_val[k] = '0;
    m_bl = '0; m_er = '0; m_seen = '0; m_obl = '0; m_oer = '0;
    m_dig = '0; m_fv = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic step(input logic [DIGITS-1:0] sel, input logic [6:0] seg,
                      input logic rdy, input logic rst);
    logic       cap, done;
    logic [5:0] d;
    digit_sel = sel; segments = seg; frame_ready = rdy; reset = rst;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      // A pair is captured once it has sat in the stage register S edges in a row.
      cap = ($countones(hist[0][PW-1:7]) == 1) && (hist[S] != hist[0]);
      for (int j = 1; j < S; j++) if (hist[j] != hist[0]) cap = 1'b0;
      done = 1'b0;
      if (cap) begin
        d = ref_decode(hist[0][6:0]);
        for (int k = 0; k < DIGITS; k++) begin
          if (hist[0][7+k]) begin
            m_val[k] = d[3:0]; m_bl[k] = d[5]; m_er[k] = d[4]; m_seen[k] = 1'b1;
          end
        end
        if (&m_seen) begin
          done = 1'b1;
          m_seen = '0;
          if (!m_fv || rdy) begin
            m_fv = 1'b1; m_obl = m_bl; m_oer = m_er;
            for (int k = 0; k < DIGITS; k++) m_dig[4*k +: 4] = m_val[k];
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
      if (!done && m_fv && rdy) m_fv = 1'b0;
      for (int j = S; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {sel, seg};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(DIGITS'($urandom), 7'($urandom), 1'($urandom), 1'b1);
    step(DIGITS'($urandom), 7'($urandom), 1'($urandom), 1'b1);
    cmp++;
    if (obs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", obs());
    end
    cmp++;
    if (obs() !== expm()) begin
      fails++; $display("FAIL reset_model: got %h want %h", obs(), expm());
    end
  endtask

  task automatic test_normal_frame();
    logic [6:0] pats [4] = '{7'h6D, 7'h7E, 7'h6D, 7'h5B};
    int rises = 0, rise_at = -1;
    logic prev_fv = 1'b0;
    logic [4*DIGITS-1:0] dig_at = '0;
    logic [2*DIGITS-1:0] be_at = '1;
    step('0, '0, 1'b1, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 6; c++) begin
        step(DIGITS'(1) << p, pats[p], 1'b1, 1'b0);
        cmp++;
        if (obs() !== expm()) begin
          fails++; $display("FAIL normal_track: got %h want %h", obs(), expm());
        end
        if (frame_valid && !prev_fv) begin
          rises++; rise_at = p * 6 + c; dig_at = frame_digits;
          be_at = {frame_blank, frame_err};
        end
        prev_fv = frame_valid;
      end
    end
    cmp++;
    if (rises != 1) begin fails++; $display("FAIL normal_pulses: got %0d want 1", rises); end
    cmp++;
    if (rise_at != 22) begin fails++; $display("FAIL normal_latency: got %0d want 22", rise_at); end
    cmp++;
    if (dig_at !== 16'h5202) begin fails++; $display("FAIL normal_digits: got %h want 5202", dig_at); end
    cmp++;
    if (be_at !== '0) begin fails++; $display("FAIL normal_blank_err: got %h want 0", be_at); end
  endtask

  task automatic test_glitch();
    logic [6:0] pats [4] = '{7'h30, 7'h33, 7'h5F, 7'h7B};
    step('0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) step(DIGITS'(1), 7'h30, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step('0, 7'h30, 1'b0, 1'b0);
    for (int p = 1; p < 4; p++)
      for (int c = 0; c < 6; c++) begin
        step(DIGITS'(1) << p, pats[p], 1'b0, 1'b0);
        cmp++;
        if (obs() !== expm()) begin
          fails++; $display("FAIL glitch_track: got %h want %h", obs(), expm());
        end
      end
    cmp++;
    if (frame_valid !== 1'b0) begin fails++; $display("FAIL glitch_no_frame: got %b want 0", frame_valid); end
    for (int c = 0; c < 4; c++) step(DIGITS'(1), 7'h30, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    cmp++;
    if ({frame_valid, frame_digits} !== {1'b1, 16'h9641}) begin
      fails++; $display("FAIL glitch_frame: got %b/%h want 1/9641", frame_valid, frame_digits);
    end
  endtask

  task automatic test_blank_err();
    logic [6:0] pats [4] = '{7'h7E, 7'h00, 7'h40, 7'h79};
    step('0, '0, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 6; c++) step(DIGITS'(1) << p, pats[p], 1'b0, 1'b0);
    cmp++;
    if ({frame_valid, frame_blank, frame_err, frame_digits} !== {1'b1, 4'b0010, 4'b0100, 16'h3EF0}) begin
      fails++; $display("FAIL blank_err: got %b/%b/%b/%h want 1/0010/0100/3ef0",
                        frame_valid, frame_blank, frame_err, frame_digits);
    end
    cmp++;
    if (obs() !== expm()) begin fails++; $display("FAIL blank_err_model: got %h want %h", obs(), expm()); end
  endtask

  task automatic test_backpressure();
    logic [6:0] pats [8] = '{7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F};
    step('0, '0, 1'b0, 1'b1);
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 6; c++) begin
        step(DIGITS'(1) << (p % 4), pats[p], 1'b0, 1'b0);
        cmp++;
        if (obs() !== expm()) begin
          fails++; $display("FAIL backpressure_track: got %h want %h", obs(), expm());
        end
      end
    cmp++;
    if ({frame_valid, overrun, frame_digits} !== {2'b11, 16'h4321}) begin
      fails++; $display("FAIL backpressure_hold: got %b/%b/%h want 1/1/4321", frame_valid, overrun, frame_digits);
    end
    step('0, '0, 1'b1, 1'b0);
    cmp++;
    if ({frame_valid, frame_digits} !== {1'b0, 16'h4321}) begin
      fails++; $display("FAIL backpressure_accept: got %b/%h want 0/4321", frame_valid, frame_digits);
    end
    step('0, '0, 1'b0, 1'b0);
    cmp++;
    if ({frame_valid, overrun} !== 2'b01) begin
      fails++; $display("FAIL backpressure_after: got %b/%b want 0/1", frame_valid, overrun);
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] pa [4] = '{7'h70, 7'h7F, 7'h7B, 7'h7E};
    logic [6:0] pb [4] = '{7'h30, 7'h6D, 7'h79, 7'h33};
    step('0, '0, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 6; c++) step(DIGITS'(1) << p, pa[p], 1'b0, 1'b0);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 6; c++) step(DIGITS'(1) << p, pb[p], 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step(DIGITS'(8), pb[3], 1'b0, 1'b0);
    cmp++;
    if ({frame_valid, frame_digits} !== {1'b1, 16'h0987}) begin
      fails++; $display("FAIL simul_before: got %b/%h want 1/0987", frame_valid, frame_digits);
    end
    step(DIGITS'(8), pb[3], 1'b1, 1'b0);
    cmp++;
    if ({frame_valid, overrun, frame_digits} !== {2'b10, 16'h4321}) begin
      fails++; $display("FAIL simul_edge: got %b/%b/%h want 1/0/4321", frame_valid, overrun, frame_digits);
    end
    step(DIGITS'(8), pb[3], 1'b0, 1'b0);
    cmp++;
    if ({frame_valid, frame_digits} !== {1'b1, 16'h4321}) begin
      fails++; $display("FAIL simul_hold: got %b/%h want 1/4321", frame_valid, frame_digits);
    end
    step('0, '0, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 6; c++) step(DIGITS'(1) << p, pa[p], 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1);
    for (int p = 2; p < 4; p++)
      for (int c = 0; c < 6; c++) step(DIGITS'(1) << p, pa[p], 1'b0, 1'b0);
    cmp++;
    if (frame_valid !== 1'b0) begin fails++; $display("FAIL midscan_reset: got %b want 0", frame_valid); end
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 6; c++) step(DIGITS'(1) << p, pa[p], 1'b0, 1'b0);
    cmp++;
    if ({frame_valid, frame_digits} !== {1'b1, 16'h0987}) begin
      fails++; $display("FAIL midscan_refill: got %b/%h want 1/0987", frame_valid, frame_digits);
    end
  endtask

  task automatic test_random();
    logic [DIGITS-1:0] sel;
    logic [6:0]        seg;
    logic              rdy = 1'b0;
    int                r, hold;
    step('0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       sel = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
      else if (r == 8) sel = '0;
      else             sel = DIGITS'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       seg = PAT[$urandom_range(0, 9)];
      else if (r == 7) seg = 7'h00;
      else             seg = 7'($urandom);
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 2) == 0) rdy = ~rdy;
        step(sel, seg, rdy, ($urandom_range(0, 299) == 0));
        cmp++;
        if (obs() !== expm()) begin
          fails++; $display("FAIL random_track n=%0d: got %h want %h", n, obs(), expm());
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_normal_frame();
    test_glitch();
    test_blank_err();
    test_backpressure();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads a multiplexed seven-segment display bus (segment lines plus one-hot digit select) and reconstructs the decimal digit shown on each position.
- Each (segments, digit_sel) pair must be stable before it is accepted. The pattern is then decoded back to a 4-bit value.
- Once every digit position has been captured, the block presents a whole frame on a valid/ready output.
- Used by self-checking display paths and panel-readback logic.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive cycles a pair must be held before capture (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- segments  input  7  segment lines {a,b,c,d,e,f,g}; a is bit 6, g is bit 0; 1 = segment lit.
- digit_sel  input  DIGITS  one-hot active-high position select; bit i = position i.
- frame_valid  output  1  a frame is held on the frame_* outputs.
- frame_ready  input  1  consumer accepts the frame.
- frame_digits  output  4*DIGITS  decoded value; position i is at [4i+3:4i].
- frame_blank  output  DIGITS  position i showed all segments off.
- frame_err  output  DIGITS  position i showed an unrecognised pattern.
- overrun  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset:
  - All outputs go to 0.
  - The stage register, stability counter, per-position seen bits and shadow slots are cleared.
  - Reset mid-frame or with frame_valid high discards all partial and pending data.
- Stage register: {segments, digit_sel} is registered every cycle. All later logic uses only the registered copy.
- Stability:
  - The counter increments while the stage register is unchanged and digit_sel is one-hot. It saturates at STABLE_CYCLES.
  - Any change, or a non-one-hot select (zero or multiple bits), reloads the counter: to 1 if the new select is one-hot, otherwise to 0.
  - Capture happens once, on the edge ending the STABLE_CYCLES-th consecutive cycle. No further capture occurs until the pair changes.
- Decode, with the pattern written as 7-bit hex abc_defg:
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
  - 00 gives value F, blank=1.
  - Any other pattern gives value E, err=1.
  - Blank and err are mutually exclusive.
- Capture writes value, blank and err into shadow slot i and sets seen[i].
  - A repeat capture of an already-seen position overwrites the slot; seen stays set.
- Frame completion: evaluated on the same edge as a capture, using the post-capture seen bits.
  - If all seen bits are 1 and the output is free (frame_valid=0, or frame_valid&&frame_ready this cycle):
    - shadow slots are loaded into the frame_* outputs;
    - frame_valid goes to 1;
    - seen is cleared.
  - If the output is occupied and not being accepted:
    - the new frame is dropped;
    - seen is cleared;
    - overrun is set to 1 and stays set until reset.
- Handshake:
  - frame_* outputs stay stable while frame_valid=1 and frame_ready=0.
  - frame_valid&&frame_ready with no simultaneous completion clears frame_valid on the next edge. The data outputs keep their last values.
  - Handshake and completion on the same edge load the new frame; frame_valid stays 1.
  - frame_ready is ignored while frame_valid=0.
- Latency: a pair driven before edge e0 and held is stage-registered at e0 and captured at e0+STABLE_CYCLES. If it completes the frame, frame_valid is high after that same edge.
- Width rule: the stability counter is wide enough to hold STABLE_CYCLES with no wrap.

Test Plan:
- Reset check: assert reset for 2 cycles with random inputs -> frame_valid=0, frame_digits=0, frame_blank=0, frame_err=0, overrun=0.
- Normal frame: DIGITS=4, STABLE_CYCLES=4, frame_ready=1. Drive sel=0001/6D, 0010/7E, 0100/6D, 1000/5B, each held 6 cycles -> one frame_valid pulse with frame_digits=16'h5202, blank=0, err=0. Valid rises exactly 4 edges after the stage register loads the last pair.
- Glitch rejection: hold sel=0001/30 for 3 cycles, then sel=0000 -> no capture. Completing positions 1..3 then gives no frame until position 0 is held >=4 cycles.
- Blank and error: position 1 = 00, position 2 = 40, others valid -> frame_blank=4'b0010, frame_err=4'b0100, nibbles 1 and 2 = F and E.
- Backpressure and overrun: frame_ready=0, scan two complete frames -> first frame held unchanged, overrun=1. Raising frame_ready for one cycle yields the first frame only; frame_valid then drops.
- Simultaneous events: raise frame_ready on the exact edge the next frame's last capture occurs -> frame_valid stays 1 and frame_digits changes to the new frame on that edge. Reset asserted mid-scan -> the next frame requires all positions re-captured.
